// File: rtl/clock_div_multi.sv
// clock_div_multi: several independent integer clock dividers sharing one
// system clock. Each channel has a runtime-programmable divisor N >= 2 and
// produces a near-50% divided clock plus a one-cycle tick at every wrap.
// New divisors arrive through a valid/ready port, wait in a one-deep pending
// slot, and replace the active divisor only when the channel wraps (or on
// sync), so a period is never cut short.
module clock_div_multi #(
    parameter  int CHANNELS    = 4,
    parameter  int WIDTH       = 16,
    parameter  int DEFAULT_DIV = 2,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync,
    input  logic                cfg_valid,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [WIDTH-1:0]    cfg_div,
    output logic                cfg_ready,
    output logic                cfg_error,
    output logic [CHANNELS-1:0] div_clock,
    output logic [CHANNELS-1:0] tick
);

    // CHANNELS always fits in one bit more than the channel index.
    localparam logic [CH_W:0]    CHAN_LIMIT = (CH_W + 1)'(CHANNELS);
    localparam logic [WIDTH-1:0] RESET_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO        = WIDTH'(2);

    logic                chan_in_range;
    logic                div_legal;
    logic                cfg_fire;
    logic                cfg_store;
    logic                cfg_error_d;
    logic                cfg_error_q;
    logic [CHANNELS-1:0] pending;

    // Handshake decode: ready reflects the addressed channel's pending slot,
    // an out-of-range channel is always ready so its request can be rejected.
    always_comb begin
        chan_in_range = ({1'b0, cfg_chan} < CHAN_LIMIT);
        cfg_ready     = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
        div_legal   = (cfg_div >= TWO);
        cfg_fire    = cfg_valid & cfg_ready;
        cfg_store   = cfg_fire & chan_in_range & div_legal;
        cfg_error_d = cfg_fire & ~(chan_in_range & div_legal);
    end

    // Error pulse register: one cycle high after a rejected transfer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cfg_error_q <= 1'b0;
        end else begin
            cfg_error_q <= cfg_error_d;
        end
    end

    assign cfg_error = cfg_error_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [WIDTH-1:0] div_q;
        logic [WIDTH-1:0] div_d;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic [WIDTH-1:0] pend_q;
        logic [WIDTH-1:0] pend_d;
        logic             flag_q;
        logic             flag_d;
        logic             dclk_q;
        logic             dclk_d;
        logic             tick_q;
        logic             tick_d;
        logic [WIDTH-1:0] half;
        logic             wrap;
        logic             load_here;

        // Channel next state: sync restarts the phase, otherwise count when
        // enabled; the pending divisor is swapped in only as the counter
        // returns to zero, and the high time uses the divisor now in force.
        always_comb begin
            div_d     = div_q;
            cnt_d     = cnt_q;
            pend_d    = pend_q;
            flag_d    = flag_q;
            dclk_d    = dclk_q;
            tick_d    = 1'b0;
            half      = '0;
            wrap      = (cnt_q == (div_q - ONE));
            load_here = cfg_store & (cfg_chan == CH_W'(g));

            if (sync) begin
                cnt_d  = '0;
                dclk_d = 1'b1;
                tick_d = 1'b1;
                if (flag_q) begin
                    div_d  = pend_q;
                    flag_d = 1'b0;
                end
            end else if (enable[g]) begin
                if (wrap) begin
                    cnt_d = '0;
                    if (flag_q) begin
                        div_d  = pend_q;
                        flag_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
                half   = div_d - (div_d >> 1);
                dclk_d = (cnt_d < half);
                tick_d = (cnt_d == '0);
            end

            if (load_here) begin
                pend_d = cfg_div;
                flag_d = 1'b1;
            end
        end

        // Channel state registers, cleared to the reset divisor and idle.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                div_q  <= RESET_DIV;
                cnt_q  <= '0;
                pend_q <= RESET_DIV;
                flag_q <= 1'b0;
                dclk_q <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                div_q  <= div_d;
                cnt_q  <= cnt_d;
                pend_q <= pend_d;
                flag_q <= flag_d;
                dclk_q <= dclk_d;
                tick_q <= tick_d;
            end
        end

        assign pending[g]   = flag_q;
        assign div_clock[g] = dclk_q;
        assign tick[g]      = tick_q;
    end

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench for clock_div_multi. Two instances share the clock and
// reset: a 4-channel 16-bit one and a 3-channel 4-bit one (the latter can be
// addressed with an out-of-range channel and can run N = 15 at full width).
module tb_clock_div_multi;

    logic       clock;
    logic       reset_n;

    logic [3:0]  en0;
    logic        sync0;
    logic        val0;
    logic [1:0]  chan0;
    logic [15:0] div0;
    logic        rdy0;
    logic        err0;
    logic [3:0]  dclk0;
    logic [3:0]  tick0;

    logic [2:0]  en1;
    logic        sync1;
    logic        val1;
    logic [1:0]  chan1;
    logic [3:0]  div1;
    logic        rdy1;
    logic        err1;
    logic [2:0]  dclk1;
    logic [2:0]  tick1;

    int errors;
    int checks;

    // Reference model: per channel the active period D, the number of
    // enabled edges elapsed in the current period, and a pending request.
    int mD[2][4];
    int mPh[2][4];
    int mP[2][4];
    bit mF[2][4];
    bit mClk[2][4];
    bit mTick[2][4];
    bit mErr[2];
    bit mXfer[2];

    clock_div_multi #(.CHANNELS(4), .WIDTH(16), .DEFAULT_DIV(2)) dut0 (
        .clock(clock), .reset_n(reset_n), .enable(en0), .sync(sync0),
        .cfg_valid(val0), .cfg_chan(chan0), .cfg_div(div0),
        .cfg_ready(rdy0), .cfg_error(err0), .div_clock(dclk0), .tick(tick0)
    );

    clock_div_multi #(.CHANNELS(3), .WIDTH(4), .DEFAULT_DIV(2)) dut1 (
        .clock(clock), .reset_n(reset_n), .enable(en1), .sync(sync1),
        .cfg_valid(val1), .cfg_chan(chan1), .cfg_div(div1),
        .cfg_ready(rdy1), .cfg_error(err1), .div_clock(dclk1), .tick(tick1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int chanCount(int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic bit modelReady(int k, int ch);
        if (ch < chanCount(k)) return !mF[k][ch];
        return 1'b1;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
                mD[k][i]    = 2;
                mPh[k][i]   = 0;
                mP[k][i]    = 2;
                mF[k][i]    = 1'b0;
                mClk[k][i]  = 1'b0;
                mTick[k][i] = 1'b0;
            end
            mErr[k]  = 1'b0;
            mXfer[k] = 1'b0;
        end
    endtask

    // One rising edge of the model for instance k with the given inputs.
    task automatic modelEdge(int k, logic [3:0] en, bit sy, bit v, int ch, int dv);
        bit xf;
        xf       = v && modelReady(k, ch);
        mXfer[k] = xf;
        mErr[k]  = xf && (ch >= chanCount(k) || dv < 2);
        for (int i = 0; i < chanCount(k); i++) begin
            if (sy) begin
                mPh[k][i] = 0;
                if (mF[k][i]) begin
                    mD[k][i] = mP[k][i];
                    mF[k][i] = 1'b0;
                end
                mClk[k][i]  = 1'b1;
                mTick[k][i] = 1'b1;
            end else if (en[i]) begin
                mPh[k][i] = mPh[k][i] + 1;
                if (mPh[k][i] == mD[k][i]) begin
                    mPh[k][i] = 0;
                    if (mF[k][i]) begin
                        mD[k][i] = mP[k][i];
                        mF[k][i] = 1'b0;
                    end
                end
                mClk[k][i]  = (mPh[k][i] < (mD[k][i] + 1) / 2);
                mTick[k][i] = (mPh[k][i] == 0);
            end else begin
                mTick[k][i] = 1'b0;
            end
            if (xf && ch == i && dv >= 2) begin
                mP[k][i] = dv;
                mF[k][i] = 1'b1;
            end
        end
    endtask

    task automatic checkBits(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [3:0] e0c;
        logic [3:0] e0t;
        logic [2:0] e1c;
        logic [2:0] e1t;
        for (int i = 0; i < 4; i++) begin
            e0c[i] = mClk[0][i];
            e0t[i] = mTick[0][i];
        end
        for (int i = 0; i < 3; i++) begin
            e1c[i] = mClk[1][i];
            e1t[i] = mTick[1][i];
        end
        checkBits("div_clock0", dclk0, e0c);
        checkBits("tick0", tick0, e0t);
        checkBits("cfg_error0", err0, mErr[0]);
        checkBits("div_clock1", dclk1, e1c);
        checkBits("tick1", tick1, e1t);
        checkBits("cfg_error1", err1, mErr[1]);
    endtask

    // One clock: check the combinational ready mid-cycle, then advance the
    // model on the rising edge and compare registered outputs just after it.
    task automatic applyStimulus();
        @(negedge clock);
        checkBits("cfg_ready0", rdy0, modelReady(0, chan0));
        checkBits("cfg_ready1", rdy1, modelReady(1, chan1));
        @(posedge clock);
        modelEdge(0, en0, sync0, val0, chan0, div0);
        modelEdge(1, {1'b0, en1}, sync1, val1, chan1, div1);
        #1;
        checkOutput();
    endtask

    task automatic runCycles(int n);
        for (int c = 0; c < n; c++) applyStimulus();
    endtask

    // Hold a request until the model sees it transfer, with a cycle budget.
    task automatic requestCfg(int k, int ch, int dv);
        bit done;
        done = 1'b0;
        if (k == 0) begin
            val0 = 1'b1; chan0 = 2'(ch); div0 = 16'(dv);
        end else begin
            val1 = 1'b1; chan1 = 2'(ch); div1 = 4'(dv);
        end
        for (int c = 0; c < 60 && !done; c++) begin
            applyStimulus();
            done = mXfer[k];
        end
        checkBits("cfg_handshake", done, 1);
        if (k == 0) val0 = 1'b0;
        else val1 = 1'b0;
    endtask

    task automatic checkResetValues();
        checkBits("rst_div_clock0", dclk0, 0);
        checkBits("rst_tick0", tick0, 0);
        checkBits("rst_cfg_error0", err0, 0);
        checkBits("rst_div_clock1", dclk1, 0);
        checkBits("rst_tick1", tick1, 0);
        checkBits("rst_cfg_error1", err1, 0);
    endtask

    // Assert reset between edges, check outputs cleared at once, release
    // just after the following rising edge.
    task automatic pulseReset();
        reset_n = 1'b0;
        #2;
        checkResetValues();
        @(posedge clock);
        #1;
        checkResetValues();
        reset_n = 1'b1;
        modelReset();
    endtask

    // Directed steps followed by a randomized phase, all checked cycle by
    // cycle against the model.
    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        en0 = '0; sync0 = 1'b0; val0 = 1'b0; chan0 = '0; div0 = '0;
        en1 = '0; sync1 = 1'b0; val1 = 1'b0; chan1 = '0; div1 = '0;
        modelReset();

        @(posedge clock);
        #1;
        $display("[TB] reset state");
        pulseReset();

        $display("[TB] default divide-by-2 on all channels");
        en0 = 4'hF;
        en1 = 3'h7;
        runCycles(8);
        if (!mClk[0][0]) applyStimulus();
        $display("[TB] asynchronous reset mid-period");
        pulseReset();
        runCycles(5);

        $display("[TB] ch1 divide by 5");
        requestCfg(0, 1, 5);
        runCycles(20);

        $display("[TB] ch0 divide by 7 then back-to-back request");
        requestCfg(0, 0, 7);
        requestCfg(0, 0, 3);
        runCycles(12);

        $display("[TB] rejected requests");
        requestCfg(0, 2, 1);
        runCycles(2);
        requestCfg(1, 3, 5);
        runCycles(2);
        requestCfg(1, 1, 0);
        runCycles(3);

        $display("[TB] N=3,4,6 with ch2 disabled then sync");
        requestCfg(0, 0, 3);
        requestCfg(0, 1, 4);
        requestCfg(0, 2, 6);
        runCycles(14);
        en0[2] = 1'b0;
        requestCfg(0, 2, 5);
        runCycles(10);
        sync0 = 1'b1;
        sync1 = 1'b1;
        applyStimulus();
        sync0 = 1'b0;
        sync1 = 1'b0;
        en0 = 4'hF;
        runCycles(15);

        $display("[TB] 4-bit instance, N=15");
        requestCfg(1, 0, 15);
        runCycles(40);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            en0   = 4'($urandom() | $urandom());
            en1   = 3'($urandom() | $urandom());
            sync0 = ($urandom_range(0, 39) == 0);
            sync1 = ($urandom_range(0, 39) == 0);
            if (!val0 && $urandom_range(0, 5) == 0) begin
                val0  = 1'b1;
                chan0 = 2'($urandom_range(0, 3));
                div0  = 16'($urandom_range(0, 12));
            end
            if (!val1 && $urandom_range(0, 5) == 0) begin
                val1  = 1'b1;
                chan1 = 2'($urandom_range(0, 3));
                div1  = 4'($urandom_range(0, 15));
            end
            applyStimulus();
            if (mXfer[0]) val0 = 1'b0;
            if (mXfer[1]) val1 = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
